universal_shift_reg_n: RTL and testbench
========================================

# universal_shift_reg_n

Parametrised universal shift register: hold, logical shift right/left with serial fill, parallel load, clear, and optional rotate and arithmetic-shift modes. Adds a multi-cycle burst engine that applies one shift operation a programmed number of times under a start/busy/done handshake. It is the generalised successor of the 4-bit universal shift register and serves serialiser and datapath-alignment logic in the lab ASIC designs.

## Interface
Parameters:
- WIDTH, 4, register width in bits (≥2)
- CNTW, $clog2(WIDTH+1), burst-count field width

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  reset, asynchronous, active-low (asserted at 0)
- en  in  1  enables single-step operation when no burst is active
- mode  in  3  operation select (see Operation)
- sin_r  in  1  serial fill bit for right shift (enters MSB)
- sin_l  in  1  serial fill bit for left shift (enters LSB)
- din  in  WIDTH  parallel load data
- start  in  1  request burst of `amount` steps of `mode`
- amount  in  CNTW  burst step count
- q  out  WIDTH  register contents
- sout_r  out  1  q[0] (bit leaving on right shift)
- sout_l  out  1  q[WIDTH-1] (bit leaving on left shift)
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse after last burst step

## Operation
- Modes: 000 HOLD; 001 SHR (q <= {sin_r, q[W-1:1]}); 010 SHL (q <= {q[W-2:0], sin_l}); 011 LOAD (q <= din); 100 ROTR; 101 ROTL; 110 ASHR (MSB replicated); 111 CLEAR (q <= 0).
- FSM states IDLE, BURST.
- IDLE: start=1 latches mode and amount. amount=0 or mode in {HOLD, LOAD, CLEAR} → one step of that mode (HOLD: none), done pulse next cycle, stay IDLE, busy never asserted. Otherwise → BURST, first step performed on the same edge, remaining counter = amount-1.
- IDLE with start=0 and en=1: one step of `mode` per cycle. en=0: hold.
- BURST: one step of latched mode per cycle; sin_r/sin_l sampled live each cycle. Counter reaching 0 → IDLE with done pulse. start, en, mode, amount ignored while busy.
- start has priority over en in IDLE.

## Timing
- Reset (async assert, sync release): q=0, busy=0, done=0, FSM IDLE, counter 0. Reset mid-burst aborts immediately; no done pulse.
- All outputs registered except sout_r/sout_l (direct wires from q).
- Single step: q updates on the edge where en=1 is sampled; visible in the following cycle.
- Burst of N≥1 shift steps: busy high for N-1 cycles after the start edge (N=1: never high); q final after N edges; done high for exactly the cycle following the final step edge.
- Back-to-back: start sampled in the done cycle is accepted.
- amount > WIDTH permitted; rotates wrap modulo WIDTH, shifts saturate to fill value.

## Configuration
- USR_ROTATE_EN defined: ROTR, ROTL, ASHR implemented as above.
- Undefined: modes 100/101/110 decode as HOLD (no change to q; bursts complete as single no-op step with done pulse); rotate/ASHR logic absent from netlist.

## Structure
- Package usr_pkg: 3-bit mode enum (USR_HOLD … USR_CLEAR), FSM state enum.
- Sub-module usr_step: combinational next-value function (q, mode, sin_r, sin_l, din → q_next), instantiated once; top holds register, FSM and counter.

## Test plan
- WIDTH=4, reset, SHR with sin_r=1 for two single steps -> q=1000 then 1100; sout_r=0.
- Reset, SHL with sin_l=1 for two single steps -> q=0001 then 0011; sout_l=0.
- LOAD din=1010 -> q=1010 next cycle; CLEAR -> q=0000.
- Macro on: q=1010, start ROTL amount=3 -> busy 2 cycles, q=0101, done single pulse; ASHR amount=2 from 1000 -> 1110.
- Burst SHR amount=4 from 1111 with reset pulled low after 2 steps -> q=0000, busy=0, no done.
- Macro off: q=1010, start ROTR amount=2 -> q unchanged 1010, done next cycle, busy never high.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation modes, FSM states,
// and the burst-eligibility helper (rotate/ASHR modes count only with USR_ROTATE_EN).
package usr_pkg;

  typedef enum logic [2:0] {
    USR_HOLD  = 3'b000,
    USR_SHR   = 3'b001,
    USR_SHL   = 3'b010,
    USR_LOAD  = 3'b011,
    USR_ROTR  = 3'b100,
    USR_ROTL  = 3'b101,
    USR_ASHR  = 3'b110,
    USR_CLEAR = 3'b111
  } usr_mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } usr_state_e;

  // Modes whose repetition changes q; the rest complete as a single step.
  function automatic logic usr_is_burst_mode(input usr_mode_e m);
`ifdef USR_ROTATE_EN
    return (m == USR_SHR) || (m == USR_SHL) || (m == USR_ROTR) ||
           (m == USR_ROTL) || (m == USR_ASHR);
`else
    return (m == USR_SHR) || (m == USR_SHL);
`endif
  endfunction

endpackage

// File: rtl/usr_step.sv
// Combinational next-value function of the shift register for one step.
// Rotate and arithmetic-shift decode exists only when USR_ROTATE_EN is defined.
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  usr_mode_e        mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (mode)
      USR_SHR:   q_next = {sin_r, q[WIDTH-1:1]};
      USR_SHL:   q_next = {q[WIDTH-2:0], sin_l};
      USR_LOAD:  q_next = din;
      USR_CLEAR: q_next = '0;
`ifdef USR_ROTATE_EN
      USR_ROTR:  q_next = {q[0], q[WIDTH-1:1]};
      USR_ROTL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      USR_ASHR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
`endif
      default:   q_next = q;
    endcase
  end

endmodule

// File: rtl/universal_shift_reg_n.sv
// Universal shift register with a start/busy/done burst engine that repeats one
// operation `amount` times. Define USR_ROTATE_EN to enable ROTR/ROTL/ASHR.
module universal_shift_reg_n
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] din,
  input  logic             start,
  input  logic [CNTW-1:0]  amount,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);

  usr_state_e       state_q, state_d;
  usr_mode_e        mode_q, mode_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  usr_mode_e        step_mode;
  usr_mode_e        mode_in;
  logic [WIDTH-1:0] step_val;

  assign mode_in   = usr_mode_e'(mode);
  assign step_mode = (state_q == ST_BURST) ? mode_q : mode_in;

  usr_step #(.WIDTH(WIDTH)) u_step (
    .q      (data_q),
    .mode   (step_mode),
    .sin_r  (sin_r),
    .sin_l  (sin_l),
    .din    (din),
    .q_next (step_val)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d = mode_in;
          data_d = step_val;
          // A burst of one step (or a non-repeating mode) never raises busy.
          if ((amount > CNTW'(1)) && usr_is_burst_mode(mode_in)) begin
            state_d = ST_BURST;
            cnt_d   = amount - CNTW'(1);
          end else begin
            cnt_d  = '0;
            done_d = 1'b1;
          end
        end else if (en) begin
          data_d = step_val;
        end
      end
      ST_BURST: begin
        data_d = step_val;
        cnt_d  = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_BURST);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      mode_q  <= USR_HOLD;
      cnt_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q      = data_q;
  assign sout_r = data_q[0];
  assign sout_l = data_q[WIDTH-1];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_universal_shift_reg_n.sv
// Scoreboard bench for universal_shift_reg_n: an arithmetic reference model
// predicts each cycle's outputs, a separate monitor pops and compares them.
module tb_universal_shift_reg_n;

  localparam int W    = 4;
  localparam int CW   = $clog2(W + 1);
`ifdef USR_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic [2:0]    mode = '0;
  logic          sin_r = 1'b0;
  logic          sin_l = 1'b0;
  logic [W-1:0]  din = '0;
  logic          start = 1'b0;
  logic [CW-1:0] amount = '0;
  logic [W-1:0]  q;
  logic          sout_r, sout_l, busy, done;

  universal_shift_reg_n #(.WIDTH(W), .CNTW(CW)) dut (
    .clock(clock), .reset(reset), .en(en), .mode(mode), .sin_r(sin_r),
    .sin_l(sin_l), .din(din), .start(start), .amount(amount), .q(q),
    .sout_r(sout_r), .sout_l(sout_l), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] q;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: value, remaining burst steps, latched burst mode.
  int unsigned m_val = 0;
  int          m_rem = 0;
  int          m_mode = 0;
  bit          m_done = 0;

  function automatic int unsigned mstep(int unsigned v, int m, bit sr, bit sl, int unsigned d);
    int unsigned mask = (1 << W) - 1;
    int unsigned msb  = 1 << (W - 1);
    case (m)
      1: return (v >> 1) | (sr ? msb : 0);
      2: return ((v << 1) | sl) & mask;
      3: return d & mask;
      4: return ROT ? ((v >> 1) | ((v & 1) != 0 ? msb : 0)) : v;
      5: return ROT ? (((v << 1) & mask) | ((v & msb) != 0 ? 1 : 0)) : v;
      6: return ROT ? ((v >> 1) | (v & msb)) : v;
      7: return 0;
      default: return v;
    endcase
  endfunction

  function automatic bit repeats(int m);
    return (m == 1) || (m == 2) || (ROT && (m >= 4) && (m <= 6));
  endfunction

  task automatic model_cycle();
    exp_t e;
    if (!reset) begin
      m_val = 0; m_rem = 0; m_mode = 0; m_done = 0;
    end else if (m_rem > 0) begin
      m_val  = mstep(m_val, m_mode, sin_r, sin_l, din);
      m_rem  = m_rem - 1;
      m_done = (m_rem == 0);
    end else begin
      m_done = 0;
      if (start) begin
        m_val = mstep(m_val, mode, sin_r, sin_l, din);
        if (amount > 1 && repeats(mode)) begin
          m_mode = mode;
          m_rem  = amount - 1;
        end else begin
          m_done = 1;
        end
      end else if (en) begin
        m_val = mstep(m_val, mode, sin_r, sin_l, din);
      end
    end
    e.q    = W'(m_val);
    e.busy = (m_rem > 0);
    e.done = m_done;
    exp_q.push_back(e);
  endtask

  task automatic cyc(bit r, bit e, logic [2:0] m, bit sr, bit sl,
                     logic [W-1:0] d, bit s, logic [CW-1:0] a);
    @(negedge clock);
    #1;
    reset = r; en = e; mode = m; sin_r = sr; sin_l = sl;
    din = d; start = s; amount = a;
    model_cycle();
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: each cycle the DUT presents registered outputs, compare one entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("q", 32'(q), 32'(e.q));
        chk("busy", 32'(busy), 32'(e.busy));
        chk("done", 32'(done), 32'(e.done));
        chk("sout_r", 32'(sout_r), 32'(e.q[0]));
        chk("sout_l", 32'(sout_l), 32'(e.q[W-1]));
      end
    end
  end

  initial begin
    int guard;
    // Reset, then two SHR steps filling ones from the left.
    cyc(0, 0, 3'd0, 0, 0, 4'h0, 0, 0);
    cyc(1, 1, 3'd1, 1, 0, 4'h0, 0, 0);
    cyc(1, 1, 3'd1, 1, 0, 4'h0, 0, 0);
    cyc(1, 0, 3'd0, 0, 0, 4'h0, 0, 0);
    // Reset, then two SHL steps filling ones from the right.
    cyc(0, 0, 3'd0, 0, 0, 4'h0, 0, 0);
    cyc(1, 1, 3'd2, 0, 1, 4'h0, 0, 0);
    cyc(1, 1, 3'd2, 0, 1, 4'h0, 0, 0);
    // LOAD then CLEAR.
    cyc(1, 1, 3'd3, 0, 0, 4'hA, 0, 0);
    cyc(1, 1, 3'd7, 0, 0, 4'h0, 0, 0);
    // ROTL burst of 3 from 1010, then ASHR burst of 2 from 1000.
    cyc(1, 1, 3'd3, 0, 0, 4'hA, 0, 0);
    cyc(1, 0, 3'd5, 0, 0, 4'h0, 1, 3);
    cyc(1, 1, 3'd7, 0, 0, 4'h0, 1, 1);
    cyc(1, 1, 3'd7, 0, 0, 4'h0, 1, 1);
    cyc(1, 0, 3'd0, 0, 0, 4'h0, 0, 0);
    cyc(1, 1, 3'd3, 0, 0, 4'h8, 0, 0);
    cyc(1, 0, 3'd6, 0, 0, 4'h0, 1, 2);
    cyc(1, 0, 3'd0, 0, 0, 4'h0, 0, 0);
    // ROTR burst of 2 from 1010 (a no-op single step without rotate support).
    cyc(1, 1, 3'd3, 0, 0, 4'hA, 0, 0);
    cyc(1, 0, 3'd4, 0, 0, 4'h0, 1, 2);
    cyc(1, 0, 3'd0, 0, 0, 4'h0, 0, 0);
    cyc(1, 0, 3'd0, 0, 0, 4'h0, 0, 0);
    // SHR burst of 4 from 1111 aborted by reset after two steps.
    cyc(1, 1, 3'd3, 0, 0, 4'hF, 0, 0);
    cyc(1, 0, 3'd1, 0, 0, 4'h0, 1, 4);
    cyc(1, 0, 3'd0, 0, 0, 4'h0, 0, 0);
    cyc(0, 0, 3'd0, 0, 0, 4'h0, 0, 0);
    cyc(1, 0, 3'd0, 0, 0, 4'h0, 0, 0);
    // Back-to-back bursts with start held in the done cycle; amount > WIDTH.
    cyc(1, 1, 3'd3, 0, 0, 4'h9, 0, 0);
    cyc(1, 0, 3'd1, 1, 0, 4'h0, 1, 2);
    cyc(1, 0, 3'd2, 0, 1, 4'h0, 1, 7);
    for (int i = 0; i < 8; i++) cyc(1, 0, 3'd2, 0, 1, 4'h0, 1, 7);
    cyc(1, 0, 3'd0, 0, 0, 4'h0, 0, 0);
    // Randomized traffic with live serial inputs and occasional resets.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 1) == 1),
          3'($urandom_range(0, 7)), ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)),
          ($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7)));
    end
    cyc(1, 0, 3'd0, 0, 0, 4'h0, 0, 0);
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(negedge clock);
      guard++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
